// File: rtl/spi_mstr_param.sv
// Parameterised SPI master: CPOL/CPHA per transaction, NSS active-low selects, guard porches.
// Define SPI_MSTR_LSB_FIRST_EN to add the lsb_first input (LSB-first shift and assembly).
module spi_mstr_param #(
  parameter int WIDTH = 16,
  parameter int DIV   = 16,
  parameter int PORCH = 8,
  parameter int NSS   = 1,
  localparam int SSW  = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [WIDTH-1:0] cmd,
  input  logic [SSW-1:0]   ss_sel,
  input  logic             cpol,
  input  logic             cpha,
`ifdef SPI_MSTR_LSB_FIRST_EN
  input  logic             lsb_first,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             SCLK,
  output logic [NSS-1:0]   SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  // Handshake: wrt is a one-cycle request accepted only while busy is low; any other wrt is dropped.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (PORCH > 1) ? $clog2(PORCH) : 1;
  localparam int EW = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {IDLE, FRONT, XFER, BACK} state_t;

  state_t           state_q;
  logic [PW-1:0]    por_q;
  logic [DW-1:0]    div_q;
  logic [EW-1:0]    edge_q;
  logic [WIDTH-1:0] tx_q, rx_q, rd_q;
  logic             cpol_q, cpha_q, lsb_q;
  logic             sclk_q, mosi_q, done_q, busy_q;
  logic [NSS-1:0]   ss_n_q;

  logic             lsb_d;
  logic [SSW-1:0]   sel_d;
  logic [NSS-1:0]   ss_d;
  logic             cmd_first_d, tx_bit_d;
  logic [WIDTH-1:0] cmd_rest_d, tx_shift_d, rx_shift_d;
  logic             tick_d, last_d, lead_d, sample_d, advance_d;

`ifdef SPI_MSTR_LSB_FIRST_EN
  assign lsb_d = lsb_first;
`else
  assign lsb_d = 1'b0;
`endif

  // Out-of-range selects fall back to slave 0.
  assign sel_d = (32'(ss_sel) < NSS) ? ss_sel : '0;

  always_comb begin
    ss_d = '1;
    for (int i = 0; i < NSS; i++) begin
      if (SSW'(i) == sel_d) ss_d[i] = 1'b0;
    end
  end

  assign cmd_first_d = lsb_d ? cmd[0] : cmd[WIDTH-1];
  assign cmd_rest_d  = lsb_d ? (cmd >> 1) : (cmd << 1);
  assign tx_bit_d    = lsb_q ? tx_q[0] : tx_q[WIDTH-1];
  assign tx_shift_d  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
  assign rx_shift_d  = lsb_q ? {MISO, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], MISO};

  // edge_q counts SCLK toggles; even indices are leading edges, odd ones trailing.
  assign tick_d    = (div_q == DW'(DIV - 1));
  assign last_d    = (edge_q == EW'(2 * WIDTH - 1));
  assign lead_d    = ~edge_q[0];
  assign sample_d  = cpha_q ? ~lead_d : lead_d;
  assign advance_d = cpha_q ? lead_d : (~lead_d & ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      por_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ss_n_q  <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (wrt) begin
            state_q <= FRONT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ss_n_q  <= ss_d;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            lsb_q   <= lsb_d;
            sclk_q  <= cpol;
            rx_q    <= '0;
            por_q   <= '0;
            // With cpha=1 the first bit only appears on the first leading edge.
            if (cpha) begin
              tx_q <= cmd;
            end else begin
              tx_q   <= cmd_rest_d;
              mosi_q <= cmd_first_d;
            end
          end
        end
        FRONT: begin
          if (por_q == PW'(PORCH - 1)) begin
            state_q <= XFER;
            por_q   <= '0;
            div_q   <= '0;
            edge_q  <= '0;
          end else begin
            por_q <= por_q + 1'b1;
          end
        end
        XFER: begin
          if (tick_d) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (sample_d) rx_q <= rx_shift_d;
            if (advance_d) begin
              mosi_q <= tx_bit_d;
              tx_q   <= tx_shift_d;
            end
            if (last_d) begin
              state_q <= BACK;
              edge_q  <= '0;
              por_q   <= '0;
            end else begin
              edge_q <= edge_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        BACK: begin
          if (por_q == PW'(PORCH - 1)) begin
            state_q <= IDLE;
            por_q   <= '0;
            ss_n_q  <= '1;
            rd_q    <= rx_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            por_q <= por_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_q;
  assign SCLK    = sclk_q;
  assign SS_n    = ss_n_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_mstr_param.sv
// Bench for spi_mstr_param: one default-parameter instance plus two small instances (NSS=4, NSS=3).
`timescale 1ns/1ps
module tb_spi_mstr_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // default instance
  logic        wrt_a = 1'b0;
  logic [15:0] cmd_a = '0;
  logic        ss_sel_a = 1'b0;
  logic        cpol_a = 1'b0, cpha_a = 1'b0;
  logic        busy_a, done_a, sclk_a, mosi_a, miso_a;
  logic [15:0] rd_a;
  logic [0:0]  ss_n_a;

  // small instances share stimulus
  logic        wrt_s = 1'b0;
  logic [7:0]  cmd_s = '0;
  logic [1:0]  ss_sel_s = '0;
  logic        cpol_s = 1'b0, cpha_s = 1'b0;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic        busy_c, done_c, sclk_c, mosi_c;
  logic [7:0]  rd_b, rd_c;
  logic [3:0]  ss_n_b;
  logic [2:0]  ss_n_c;
`ifdef SPI_MSTR_LSB_FIRST_EN
  logic        lsb_a = 1'b0;
  logic        lsb_s = 1'b0;
`endif

  logic [15:0] exp_a_q[$];
  logic [7:0]  exp_b_q[$];
  logic [7:0]  exp_c_q[$];

  // slave model for the default instance: loopback, or shift out reply_a on leading edges
  logic        loop_a = 1'b1;
  logic [15:0] reply_a = '0;
  int          rbit_a = -1;
  logic        miso_rep = 1'b0;
  assign miso_a = loop_a ? mosi_a : miso_rep;

  always @(sclk_a) begin
    if (!loop_a && (sclk_a !== cpol_a) && rbit_a >= 0) begin
      miso_rep = reply_a[rbit_a];
      rbit_a--;
    end
  end

  int          rise_a = 0, rise_b = 0;
  logic [15:0] cap_a = '0;
  logic [7:0]  cap_b = '0;
  always @(posedge sclk_a) begin
    rise_a++;
    cap_a = {cap_a[14:0], mosi_a};
  end
  always @(posedge sclk_b) begin
    rise_b++;
    cap_b = {cap_b[6:0], mosi_b};
  end

  spi_mstr_param u_a (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_a), .cmd(cmd_a), .ss_sel(ss_sel_a),
    .cpol(cpol_a), .cpha(cpha_a),
`ifdef SPI_MSTR_LSB_FIRST_EN
    .lsb_first(lsb_a),
`endif
    .busy(busy_a), .done(done_a), .rd_data(rd_a), .SCLK(sclk_a),
    .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_mstr_param #(.WIDTH(8), .DIV(2), .PORCH(1), .NSS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_s), .cmd(cmd_s), .ss_sel(ss_sel_s),
    .cpol(cpol_s), .cpha(cpha_s),
`ifdef SPI_MSTR_LSB_FIRST_EN
    .lsb_first(lsb_s),
`endif
    .busy(busy_b), .done(done_b), .rd_data(rd_b), .SCLK(sclk_b),
    .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(mosi_b)
  );

  spi_mstr_param #(.WIDTH(8), .DIV(2), .PORCH(1), .NSS(3)) u_c (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_s), .cmd(cmd_s), .ss_sel(ss_sel_s),
    .cpol(cpol_s), .cpha(cpha_s),
`ifdef SPI_MSTR_LSB_FIRST_EN
    .lsb_first(lsb_s),
`endif
    .busy(busy_c), .done(done_c), .rd_data(rd_c), .SCLK(sclk_c),
    .SS_n(ss_n_c), .MOSI(mosi_c), .MISO(mosi_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboards: pop on each rising done
  logic done_a_p = 1'b0, done_b_p = 1'b0, done_c_p = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_a_p) begin
      if (exp_a_q.size() != 0) chk("a_rd_data", 32'(rd_a), 32'(exp_a_q.pop_front()));
      else chk("a_unexpected_done", 32'(exp_a_q.size()), 32'd1);
    end
    if (done_b && !done_b_p) begin
      if (exp_b_q.size() != 0) chk("b_rd_data", 32'(rd_b), 32'(exp_b_q.pop_front()));
      else chk("b_unexpected_done", 32'(exp_b_q.size()), 32'd1);
    end
    if (done_c && !done_c_p) begin
      if (exp_c_q.size() != 0) chk("c_rd_data", 32'(rd_c), 32'(exp_c_q.pop_front()));
      else chk("c_unexpected_done", 32'(exp_c_q.size()), 32'd1);
    end
    done_a_p = done_a;
    done_b_p = done_b;
    done_c_p = done_c;
  end

  // MOSI may only move together with a falling SCLK while mon_a is set
  logic mon_a = 1'b0;
  logic mosi_prev = 1'b0, sclk_prev = 1'b0;
  int   mosi_chg = 0;
  always @(negedge clk) begin
    if (mon_a && (mosi_a !== mosi_prev)) begin
      mosi_chg++;
      chk("a_mosi_on_fall", {30'd0, sclk_prev, sclk_a}, 32'd2);
    end
    mosi_prev = mosi_a;
    sclk_prev = sclk_a;
  end

  task automatic run_a(input logic [15:0] c, input logic pol, input logic pha,
                       input logic [15:0] exp, input logic poke);
    int cnt;
    @(negedge clk);
    chk("a_gap_ss", 32'(ss_n_a), 32'd1);
    cmd_a = c; cpol_a = pol; cpha_a = pha; wrt_a = 1'b1;
    exp_a_q.push_back(exp);
    @(posedge clk); #1;
    wrt_a = 1'b0; cnt = 1; rise_a = 0;
    chk("a_busy", 32'(busy_a), 32'd1);
    chk("a_ss_low", 32'(ss_n_a), 32'd0);
    chk("a_done_clr", 32'(done_a), 32'd0);
    chk("a_sclk_front", 32'(sclk_a), 32'(pol));
    while (!done_a && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
      wrt_a = poke && (cnt == 200);
      if (wrt_a) cmd_a = ~c;
    end
    wrt_a = 1'b0;
    chk("a_done_seen", 32'(done_a), 32'd1);
    chk("a_latency", 32'(cnt), 32'd529);
    chk("a_sclk_rises", 32'(rise_a), 32'd16);
    chk("a_busy_end", 32'(busy_a), 32'd0);
    chk("a_ss_end", 32'(ss_n_a), 32'd1);
    chk("a_sclk_idle", 32'(sclk_a), 32'(pol));
    if (!pol && !pha) chk("a_mosi_bits", 32'(cap_a), 32'(c));
  endtask

  // Returns just after done so a following call issues a back-to-back wrt.
  task automatic run_s(input logic [7:0] c, input logic [1:0] sel, input logic pol,
                       input logic pha, input logic [3:0] ssb, input logic [2:0] ssc,
                       input logic [7:0] cap_exp);
    int cnt;
    chk("s_gap_ss_b", 32'(ss_n_b), 32'hF);
    chk("s_gap_ss_c", 32'(ss_n_c), 32'h7);
    cmd_s = c; ss_sel_s = sel; cpol_s = pol; cpha_s = pha; wrt_s = 1'b1;
    exp_b_q.push_back(c);
    exp_c_q.push_back(c);
    @(posedge clk); #1;
    wrt_s = 1'b0; cnt = 1; rise_b = 0;
    chk("s_ss_b", 32'(ss_n_b), 32'(ssb));
    chk("s_ss_c", 32'(ss_n_c), 32'(ssc));
    chk("s_busy_b", 32'(busy_b), 32'd1);
    while (!(done_b && done_c) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("s_done_b", 32'(done_b), 32'd1);
    chk("s_done_c", 32'(done_c), 32'd1);
    chk("s_latency", 32'(cnt), 32'd35);
    chk("s_sclk_rises", 32'(rise_b), 32'd8);
    if (!pha) chk("s_mosi_bits", 32'(cap_b), 32'(cap_exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cap01;
    logic       lsb_v;
`ifdef SPI_MSTR_LSB_FIRST_EN
    lsb_v = 1'b1;
    cap01 = 8'h80;
`else
    lsb_v = 1'b0;
    cap01 = 8'h01;
`endif
    #23;
    chk("rst_ss_a", 32'(ss_n_a), 32'd1);
    chk("rst_sclk_a", 32'(sclk_a), 32'd0);
    chk("rst_mosi_a", 32'(mosi_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_rd_a", 32'(rd_a), 32'd0);
    chk("rst_ss_b", 32'(ss_n_b), 32'hF);
    chk("rst_ss_c", 32'(ss_n_c), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // loopback, mode 0
    run_a(16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b0);

    // mode 3 with a scripted reply
    loop_a = 1'b0; reply_a = 16'h1234; rbit_a = 15; mosi_chg = 0; mon_a = 1'b1;
    run_a(16'h8001, 1'b1, 1'b1, 16'h1234, 1'b0);
    mon_a = 1'b0; loop_a = 1'b1;
    chk("a_mosi_changes", 32'(mosi_chg), 32'd2);

    // wrt during XFER must be ignored
    run_a(16'h3C96, 1'b0, 1'b0, 16'h3C96, 1'b1);
    repeat (20) @(negedge clk);
    chk("a_done_hold", 32'(done_a), 32'd1);

    // abort by reset while SCLK is high mid-XFER
    @(negedge clk);
    cmd_a = 16'h1357; cpol_a = 1'b1; cpha_a = 1'b0; wrt_a = 1'b1;
    exp_a_q.push_back(16'h1357);
    @(posedge clk); #1;
    wrt_a = 1'b0;
    chk("a_done_clr2", 32'(done_a), 32'd0);
    repeat (267) @(posedge clk);
    #2;
    chk("a_pre_rst_sclk", 32'(sclk_a), 32'd1);
    chk("a_pre_rst_ss", 32'(ss_n_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("a_arst_ss", 32'(ss_n_a), 32'd1);
    chk("a_arst_sclk", 32'(sclk_a), 32'd0);
    chk("a_arst_done", 32'(done_a), 32'd0);
    chk("a_arst_busy", 32'(busy_a), 32'd0);
    chk("a_arst_rd", 32'(rd_a), 32'd0);
    exp_a_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("a_no_done_after_abort", 32'(done_a), 32'd0);
    run_a(16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b0);

    // small instances: select decode, out-of-range select, back-to-back, bit order, mode 1
    @(negedge clk);
`ifdef SPI_MSTR_LSB_FIRST_EN
    lsb_s = 1'b0;
`endif
    run_s(8'hC5, 2'd2, 1'b0, 1'b0, 4'b1011, 3'b011, 8'hC5);
    run_s(8'h3A, 2'd3, 1'b0, 1'b0, 4'b0111, 3'b110, 8'h3A);
`ifdef SPI_MSTR_LSB_FIRST_EN
    lsb_s = lsb_v;
`endif
    run_s(8'h01, 2'd1, 1'b0, 1'b0, 4'b1101, 3'b101, cap01);
`ifdef SPI_MSTR_LSB_FIRST_EN
    lsb_s = 1'b0;
`endif
    run_s(8'h96, 2'd0, 1'b0, 1'b1, 4'b1110, 3'b110, 8'h00);
    if (lsb_v) chk("s_lsb_rd_b", 32'(rd_b), 32'h96);

    repeat (5) @(negedge clk);
    chk("a_sb_left", 32'(exp_a_q.size()), 32'd0);
    chk("b_sb_left", 32'(exp_b_q.size()), 32'd0);
    chk("c_sb_left", 32'(exp_c_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
